// File: rtl/xor_vector_driver.sv
// Stimulus initiator for the XOR classifier: offers every input vector over a valid/ready port,
// checks each returned result bit against the vector parity and reports pass/timeout/errors.
module xor_vector_driver #(
  parameter int unsigned InputsNum     = 3,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic               protocol_err_o,
  output logic [InputsNum:0] err_cnt_o,
  output logic               out_data_o [InputsNum-1:0],
  output logic               out_data_vld_o,
  input  logic               out_data_rdy_i,
  input  logic               result_data_i,
  input  logic               result_vld_i
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0]    TmoLast = CntW'(TimeoutCycles - 1);
  localparam logic [InputsNum:0] LastVec = {1'b0, {InputsNum{1'b1}}};
  localparam logic [InputsNum:0] MaxErr  = {1'b1, {InputsNum{1'b0}}};

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [InputsNum:0]   vec_q, vec_d;
  logic [InputsNum:0]   err_q, err_d;
  logic [CntW-1:0]      tcnt_q, tcnt_d;
  logic                 timeout_q, timeout_d;
  logic                 perr_q, perr_d;
  logic                 pass_q, pass_d;
  logic                 pass_now;
  logic                 exp_bit;

  assign pass_now = (err_q == '0) && !timeout_q && !perr_q;
  assign exp_bit  = ^vec_q[InputsNum-1:0];

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    perr_d    = perr_q;
    pass_d    = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d     = '0;
          timeout_d = 1'b0;
          perr_d    = 1'b0;
          pass_d    = 1'b0;
          vec_d     = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (out_data_rdy_i) begin
          tcnt_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        // A result arriving in the expiry cycle takes priority over the timeout.
        if (result_vld_i) begin
          if ((result_data_i != exp_bit) && (err_q != MaxErr)) begin
            err_d = err_q + 1'b1;
          end
          if (vec_q == LastVec) begin
            state_d = StDone;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = StSend;
          end
        end else if (tcnt_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        pass_d  = pass_now;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stray results outside WAIT are flagged; applied after the start-time clear.
    if (result_vld_i && (state_q != StWait)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      err_q     <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      perr_q    <= perr_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(InputsNum); i++) begin
      out_data_o[i] = vec_q[i];
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign pass_o         = (state_q == StDone) ? pass_now : pass_q;
  assign timeout_o      = timeout_q;
  assign protocol_err_o = perr_q;
  assign err_cnt_o      = err_q;
  assign out_data_vld_o = (state_q == StSend);

endmodule

// File: doc/xor_vector_driver.md
# xor_vector_driver

Test-stimulus initiator for the XOR classifier network: on `start` it walks every INPUTS_NUM-bit input vector, offers each one over the classifier's valid/ready input port, waits for the classifier's single-cycle result pulse, and checks the result bit against the parity of the vector. It sits on the opposite side of the classifier's `in_data`/`in_data_vld`/`in_data_rdy` and `result_data`/`result_vld` interface. It reports an error count, a pass flag and a timeout flag, and is used both in on-chip self-test and as the bench driver.

## Interface
- INPUTS_NUM, 3: input vector width; vectors 0 to 2**INPUTS_NUM-1 are applied.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before aborting; must be ≥1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE only.
- busy  out  1  high from the cycle after `start` is accepted until DONE is exited.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 = last run had err_cnt==0, no timeout and no protocol error; held until the next accepted start.
- timeout  out  1  sticky; set when a run aborts on timeout.
- protocol_err  out  1  sticky; set when `result_vld` arrives outside WAIT.
- err_cnt  out  INPUTS_NUM+1  number of mismatching results in the current or last run.
- out_data  out  1 x INPUTS_NUM (unpacked [INPUTS_NUM-1:0])  `out_data[i]` = bit i of the current vector; drives the classifier's `in_data`.
- out_data_vld  out  1  vector valid; drives `in_data_vld`.
- out_data_rdy  in  1  from `in_data_rdy`.
- result_data  in  1  classifier output bit.
- result_vld  in  1  single-cycle result strobe.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: when `start`=1, clear err_cnt, timeout, protocol_err and pass; set vec=0; go to SEND.
- SEND: `out_data_vld`=1 and `out_data`=vec, stable while `out_data_rdy`=0. On `out_data_vld && out_data_rdy`, go to WAIT and clear the timeout counter.
- WAIT: `out_data_vld`=0. The counter increments every cycle.
  - On `result_vld`:
    - if `result_data != ^vec`, err_cnt += 1;
    - if vec==2**INPUTS_NUM-1, go to DONE; otherwise vec += 1 and go to SEND.
  - If the counter reaches TIMEOUT_CYCLES-1 with no `result_vld`, set timeout=1 and go to DONE.
  - If `result_vld` and the timeout expiry fall in the same cycle, the result wins and no timeout is flagged.
- DONE: `done`=1 for exactly one cycle; `pass` = (err_cnt==0 && !timeout && !protocol_err); go to IDLE.
- `result_vld` in IDLE, SEND or DONE sets protocol_err and is otherwise ignored.
- `start` outside IDLE is ignored.
- err_cnt saturates at 2**INPUTS_NUM; it cannot exceed this in a complete run.
- vec is an INPUTS_NUM+1-bit internal counter, so the last-vector compare never wraps.
- `rst` in any state, including mid-handshake: next state IDLE and all outputs at their reset values. A vector offered but not yet accepted is dropped.

## Timing
- Reset values: busy=0, done=0, pass=0, timeout=0, protocol_err=0, err_cnt=0, out_data=all 0, out_data_vld=0.
- `start` sampled at edge t: busy=1 and out_data_vld=1 with vector 0 from t+1.
- Handshake accepted at edge h: out_data_vld=0 from h+1.
- `result_vld` sampled at edge r:
  - if not the last vector, out_data_vld=1 with the next vector from r+1;
  - after the last vector, done=1 and pass valid during r+1, then busy=0 from r+2.
- Minimum run length with a classifier of result latency L (cycles from acceptance to result) and ready always high: 2**INPUTS_NUM*(L+1)+2 cycles from start to done.
- Timeout: with the handshake at h and no result, done=1 during h+TIMEOUT_CYCLES+1.

## Test plan
- INPUTS_NUM=3, ideal responder (out_data_rdy=1, result_vld 2 cycles after acceptance, result_data=parity) → 8 vectors in order 0..7, err_cnt=0, pass=1, done pulses once.
- Responder always returns result_data=0 → err_cnt=4 (vectors 1,2,4,7), pass=0.
- out_data_rdy held low 5 cycles on vector 3 → out_data_vld and out_data={1,1,0} (i=0..2) stable for all 5 cycles, exactly one transfer.
- TIMEOUT_CYCLES=16, responder never answers vector 0 → timeout=1 and done during handshake+17, pass=0, err_cnt=0.
- result_vld pulsed in IDLE, and a second `start` pulsed in WAIT → protocol_err=1 and the run is not restarted.
- `rst` asserted in WAIT on vector 5 → next cycle all outputs at reset values; a following `start` runs from vector 0 to completion with pass=1.
